// File: rtl/gdsp_pkg.sv
// Shared DSP types and 16-QAM constellation constants for the receive chain.
// Used by qam16_axis_slicer and qam16_slicer_evm.
package gdsp_pkg;

  typedef logic signed [11:0] sample_t;
  typedef logic signed [12:0] err_t;
  typedef logic        [19:0] evm_energy_t;

  localparam sample_t QAM_NEG3  = -12'sd1943;
  localparam sample_t QAM_NEG1  = -12'sd648;
  localparam sample_t QAM_POS1  =  12'sd648;
  localparam sample_t QAM_POS3  =  12'sd1943;
  localparam sample_t SLICE_THR =  12'sd1296;

  localparam sample_t SAMPLE_MAX = 12'sh7FF;
  localparam sample_t SAMPLE_MIN = 12'sh800;

  localparam logic [1:0] GRAY_NEG3 = 2'b00;
  localparam logic [1:0] GRAY_NEG1 = 2'b01;
  localparam logic [1:0] GRAY_POS1 = 2'b11;
  localparam logic [1:0] GRAY_POS3 = 2'b10;

  typedef struct packed {
    sample_t    ref_pt;
    logic [1:0] bits;
    err_t       err;
  } slice_t;

  typedef struct packed {
    logic   valid;
    slice_t i;
    slice_t q;
  } stage1_t;

  // |e| <= 648 per axis, so each square fits in 19 bits and the sum in 20.
  function automatic evm_energy_t err_energy(input err_t e_i, input err_t e_q);
    logic signed [25:0] sq_i;
    logic signed [25:0] sq_q;
    sq_i = e_i * e_i;
    sq_q = e_q * e_q;
    return evm_energy_t'(sq_i[18:0]) + evm_energy_t'(sq_q[18:0]);
  endfunction

  function automatic logic is_sat(input sample_t x);
    return (x == SAMPLE_MAX) || (x == SAMPLE_MIN);
  endfunction

endpackage

// File: rtl/qam16_axis_slicer.sv
// One-axis hard decision for 16-QAM: nearest level, Gray bits and error.
// Purely combinational; instantiated once per I and Q axis.
import gdsp_pkg::*;

module qam16_axis_slicer (
  input  sample_t x,
  output slice_t  slice
);

  // NOTE: every output gets a default before the decision tree, so no latch can be inferred.
  always_comb begin
    slice.ref_pt = QAM_POS1;
    slice.bits   = GRAY_POS1;
    if (x < -SLICE_THR) begin
      slice.ref_pt = QAM_NEG3;
      slice.bits   = GRAY_NEG3;
    end else if (x < 12'sd0) begin
      slice.ref_pt = QAM_NEG1;
      slice.bits   = GRAY_NEG1;
    end else if (x >= SLICE_THR) begin
      slice.ref_pt = QAM_POS3;
      slice.bits   = GRAY_POS3;
    end
    slice.err = err_t'(x) - err_t'(slice.ref_pt);
  end

endmodule

// File: rtl/qam16_slicer_evm.sv
// 16-QAM slicer with windowed error-energy (EVM) accumulation.
// Optional macro SLICER_SAT_CNT_EN adds the sat_cnt output (saturated samples per window).
import gdsp_pkg::*;

module qam16_slicer_evm #(
  parameter int WIN_LOG2 = 10,
  parameter int ACC_W    = 20 + WIN_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  sample_t          rx_I,
  input  sample_t          rx_Q,
  input  logic             rx_valid,
  input  logic             clear_stats,
  output logic [3:0]       sym_out,
  output sample_t          sym_I,
  output sample_t          sym_Q,
  output logic             sym_valid,
  output logic [ACC_W-1:0] evm_acc,
  output logic             evm_valid
`ifdef SLICER_SAT_CNT_EN
  ,
  output logic [WIN_LOG2:0] sat_cnt
`endif
);

  if (ACC_W < 20 + WIN_LOG2) begin : g_acc_w_check
    $error("qam16_slicer_evm: ACC_W must be at least 20+WIN_LOG2");
  end
  if (WIN_LOG2 < 4 || WIN_LOG2 > 16) begin : g_win_check
    $error("qam16_slicer_evm: WIN_LOG2 must lie in 4..16");
  end

  slice_t               slice_i;
  slice_t               slice_q;
  stage1_t              s1;
  logic                 s2_valid;
  evm_energy_t          s2_energy;
  logic [ACC_W-1:0]     acc;
  logic [WIN_LOG2-1:0]  win_cnt;
  logic                 evm_valid_q;
  logic                 win_last;

  qam16_axis_slicer u_slice_i (.x(rx_I), .slice(slice_i));
  qam16_axis_slicer u_slice_q (.x(rx_Q), .slice(slice_q));

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else if (en) begin
      s1 <= '{valid: rx_valid, i: slice_i, q: slice_q};
    end
  end

  // S2: decision outputs aligned with the error energy of the same sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      sym_out   <= '0;
      sym_I     <= '0;
      sym_Q     <= '0;
      s2_energy <= '0;
    end else if (en) begin
      s2_valid  <= s1.valid;
      sym_out   <= {s1.i.bits, s1.q.bits};
      sym_I     <= s1.i.ref_pt;
      sym_Q     <= s1.q.ref_pt;
      s2_energy <= err_energy(s1.i.err, s1.q.err);
    end
  end

  assign win_last = &win_cnt;

  // S3: a clear restarts the window with the S2 sample of the same cycle, if any.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      win_cnt     <= '0;
      evm_acc     <= '0;
      evm_valid_q <= 1'b0;
    end else if (en) begin
      evm_valid_q <= 1'b0;
      if (clear_stats) begin
        acc     <= s2_valid ? ACC_W'(s2_energy) : '0;
        win_cnt <= s2_valid ? WIN_LOG2'(1) : '0;
      end else if (s2_valid) begin
        win_cnt <= win_cnt + WIN_LOG2'(1);
        if (win_last) begin
          evm_acc     <= acc + ACC_W'(s2_energy);
          evm_valid_q <= 1'b1;
          acc         <= '0;
        end else begin
          acc <= acc + ACC_W'(s2_energy);
        end
      end
    end
  end

  // A stalled cycle shows no valid, so a pulse is consumed exactly once.
  assign sym_valid = s2_valid & en;
  assign evm_valid = evm_valid_q & en;

`ifdef SLICER_SAT_CNT_EN
  logic                s1_sat;
  logic                s2_sat;
  logic [WIN_LOG2:0]   sat_acc;
  logic [WIN_LOG2:0]   sat_inc;

  assign sat_inc = {{WIN_LOG2{1'b0}}, s2_sat};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sat  <= 1'b0;
      s2_sat  <= 1'b0;
      sat_acc <= '0;
      sat_cnt <= '0;
    end else if (en) begin
      s1_sat <= rx_valid & (is_sat(rx_I) | is_sat(rx_Q));
      s2_sat <= s1.valid & s1_sat;
      if (clear_stats) begin
        sat_acc <= s2_valid ? sat_inc : '0;
      end else if (s2_valid) begin
        if (win_last) begin
          sat_cnt <= sat_acc + sat_inc;
          sat_acc <= '0;
        end else begin
          sat_acc <= sat_acc + sat_inc;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_qam16_slicer_evm.sv
// Self-checking bench for qam16_slicer_evm with a 16-symbol window.
// Decisions and window energies are predicted by a small pipeline model and queued.
import gdsp_pkg::*;

module tb_qam16_slicer_evm;

  localparam int WL  = 4;
  localparam int AW  = 24;
  localparam int WIN = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          rx_valid = 1'b0;
  logic          clear_stats = 1'b0;
  sample_t       rx_I = '0;
  sample_t       rx_Q = '0;
  logic [3:0]    sym_out;
  sample_t       sym_I;
  sample_t       sym_Q;
  logic          sym_valid;
  logic [AW-1:0] evm_acc;
  logic          evm_valid;
`ifdef SLICER_SAT_CNT_EN
  logic [WL:0]   sat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  qam16_slicer_evm #(.WIN_LOG2(WL), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .rx_I(rx_I), .rx_Q(rx_Q), .rx_valid(rx_valid), .clear_stats(clear_stats),
    .sym_out(sym_out), .sym_I(sym_I), .sym_Q(sym_Q), .sym_valid(sym_valid),
    .evm_acc(evm_acc), .evm_valid(evm_valid)
`ifdef SLICER_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         rx_i;
    int         rx_q;
    logic [3:0] code;
    int         ref_i;
    int         ref_q;
  } vec_t;

  typedef struct { logic [3:0] code; int ref_i; int ref_q; } sym_exp_t;
  typedef struct { int acc; int sat; } evm_exp_t;
  typedef struct { bit v; int e; int sat; } pst_t;

  sym_exp_t sym_q[$];
  evm_exp_t evm_q[$];
  pst_t     p1, p2;
  int       macc, mcnt, msat;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int energy_of(input vec_t x);
    return (x.rx_i - x.ref_i) * (x.rx_i - x.ref_i) + (x.rx_q - x.ref_q) * (x.rx_q - x.ref_q);
  endfunction

  function automatic int sat_of(input vec_t x);
    return (x.rx_i == 2047 || x.rx_i == -2048 || x.rx_q == 2047 || x.rx_q == -2048) ? 1 : 0;
  endfunction

  task automatic model_reset();
    p1 = '{v: 1'b0, e: 0, sat: 0};
    p2 = '{v: 1'b0, e: 0, sat: 0};
    macc = 0;
    mcnt = 0;
    msat = 0;
    sym_q.delete();
    evm_q.delete();
  endtask

  // One clock: drive inputs, advance the model on enabled edges.
  task automatic step(input bit v, input vec_t x, input bit clr);
    rx_valid    = v;
    rx_I        = sample_t'(x.rx_i);
    rx_Q        = sample_t'(x.rx_q);
    clear_stats = clr;
    @(posedge clk);
    if (!rst && en) begin
      if (clr) begin
        macc = p2.v ? p2.e : 0;
        mcnt = p2.v ? 1 : 0;
        msat = p2.v ? p2.sat : 0;
      end else if (p2.v) begin
        macc += p2.e;
        msat += p2.sat;
        mcnt++;
        if (mcnt == WIN) begin
          evm_q.push_back('{acc: macc, sat: msat});
          macc = 0;
          mcnt = 0;
          msat = 0;
        end
      end
      p2 = p1;
      p1 = '{v: v, e: energy_of(x), sat: sat_of(x)};
      if (v) sym_q.push_back('{code: x.code, ref_i: x.ref_i, ref_q: x.ref_q});
    end
    #1;
    rx_valid    = 1'b0;
    clear_stats = 1'b0;
  endtask

  task automatic idle(input int n);
    vec_t z;
    z = '{rx_i: 0, rx_q: 0, code: 4'b1111, ref_i: 648, ref_q: 648};
    for (int k = 0; k < n; k++) step(1'b0, z, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sym_valid) begin
        if (sym_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sym_valid: unexpected symbol sym_out=%b", sym_out);
        end else begin
          sym_exp_t s;
          s = sym_q.pop_front();
          check("sym_out", sym_out, s.code);
          check("sym_I", sym_I, s.ref_i);
          check("sym_Q", sym_Q, s.ref_q);
        end
      end
      if (evm_valid) begin
        if (evm_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL evm_valid: unexpected pulse evm_acc=%0d", evm_acc);
        end else begin
          evm_exp_t w;
          w = evm_q.pop_front();
          check("evm_acc", evm_acc, w.acc);
`ifdef SLICER_SAT_CNT_EN
          check("sat_cnt", sat_cnt, w.sat);
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[$];
    vec_t       v;
    int         pts[4];
    logic [1:0] gray[4];

    pts  = '{-1943, -648, 648, 1943};
    gray = '{2'b00, 2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++)
      for (int q = 0; q < 4; q++)
        vecs.push_back('{rx_i: pts[i], rx_q: pts[q], code: {gray[i], gray[q]},
                         ref_i: pts[i], ref_q: pts[q]});
    vecs.push_back('{rx_i: -1297, rx_q: 0, code: 4'b0011, ref_i: -1943, ref_q: 648});
    vecs.push_back('{rx_i: -1296, rx_q: 0, code: 4'b0111, ref_i: -648,  ref_q: 648});
    vecs.push_back('{rx_i: -1,    rx_q: 0, code: 4'b0111, ref_i: -648,  ref_q: 648});
    vecs.push_back('{rx_i: 0,     rx_q: 0, code: 4'b1111, ref_i: 648,   ref_q: 648});
    vecs.push_back('{rx_i: 1295,  rx_q: 0, code: 4'b1111, ref_i: 648,   ref_q: 648});
    vecs.push_back('{rx_i: 1296,  rx_q: 0, code: 4'b1011, ref_i: 1943,  ref_q: 648});

    model_reset();
    #12;
    check("reset_sym_valid", sym_valid, 0);
    check("reset_sym_out", sym_out, 0);
    check("reset_evm_acc", evm_acc, 0);
    check("reset_evm_valid", evm_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Noise-free sweep with one bubble, then the slicing thresholds.
    for (int k = 0; k < 16; k++) begin
      step(1'b1, vecs[k], 1'b0);
      if (k == 7) idle(1);
    end
    idle(4);
    check("sweep_evm_acc", evm_acc, 0);
    for (int k = 16; k < vecs.size(); k++) step(1'b1, vecs[k], 1'b0);
    idle(3);
    step(1'b0, vecs[0], 1'b1);

    // Fixed offset with gaps.
    v = '{rx_i: 700, rx_q: 700, code: 4'b1111, ref_i: 648, ref_q: 648};
    for (int k = 0; k < WIN; k++) begin
      step(1'b1, v, 1'b0);
      if (k % 3 == 2) idle(1);
    end
    idle(4);
    check("offset_evm_acc", evm_acc, 86528);

    // Rail-to-rail extremes.
    v = '{rx_i: 2047, rx_q: -2048, code: 4'b1000, ref_i: 1943, ref_q: -1943};
    for (int k = 0; k < WIN; k++) step(1'b1, v, 1'b0);
    idle(4);
    check("extreme_evm_acc", evm_acc, 349456);
`ifdef SLICER_SAT_CNT_EN
    check("extreme_sat_cnt", sat_cnt, 16);
`endif

    // Stall mid-window, then clear on the window-completing sample.
    v = '{rx_i: 700, rx_q: 700, code: 4'b1111, ref_i: 648, ref_q: 648};
    for (int k = 0; k < 10; k++) step(1'b1, v, 1'b0);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, vecs[0], 1'b0);
      check("stall_sym_valid", sym_valid, 0);
    end
    en = 1'b1;
    for (int k = 0; k < 6; k++) step(1'b1, v, 1'b0);
    step(1'b1, v, 1'b0);
    step(1'b1, v, 1'b1);
    check("clear_no_evm_valid", evm_valid, 0);
    for (int k = 0; k < 13; k++) step(1'b1, v, 1'b0);
    idle(4);

    // Async reset mid-window, then one full window with exact latency.
    v = '{rx_i: 2047, rx_q: -2048, code: 4'b1000, ref_i: 1943, ref_q: -1943};
    for (int k = 0; k < 5; k++) step(1'b1, v, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_sym_valid", sym_valid, 0);
    check("arst_sym_out", sym_out, 0);
    check("arst_sym_I", sym_I, 0);
    check("arst_evm_acc", evm_acc, 0);
    check("arst_evm_valid", evm_valid, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    v = '{rx_i: 700, rx_q: -700, code: 4'b1101, ref_i: 648, ref_q: -648};
    for (int k = 0; k < WIN; k++) step(1'b1, v, 1'b0);
    idle(1);
    check("latency_evm_valid_early", evm_valid, 0);
    idle(1);
    check("latency_evm_valid", evm_valid, 1);
    check("arst_window_evm_acc", evm_acc, 86528);

    for (int k = 0; k < 20 && (sym_q.size() != 0 || evm_q.size() != 0); k++) idle(1);
    check("pending_symbols", sym_q.size(), 0);
    check("pending_windows", evm_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
